// File: rtl/nn_neuron_mac_seq_if.sv
// rtl/nn_neuron_mac_seq_if.sv - input/output handshake and coefficient write bus for the sequential neuron
interface nn_neuron_mac_seq_if #(
  parameter int N_IN  = 6,
  parameter int IN_W  = 9,
  parameter int W_W   = 10,
  parameter int OUT_W = 8
);
  localparam int AW = $clog2(N_IN + 1);

  logic [N_IN*IN_W-1:0] in_vec;
  logic [IN_W-1:0]      in_sub;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic [W_W-1:0]       w_data;

  modport master (
    output in_vec, in_sub, in_valid, out_ready, w_we, w_addr, w_data,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_vec, in_sub, in_valid, out_ready, w_we, w_addr, w_data,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/nn_neuron_mac_seq.sv
// rtl/nn_neuron_mac_seq.sv - time-multiplexed neuron: one multiplier, N_IN cycles per result
module nn_neuron_mac_seq #(
  parameter int N_IN  = 6,
  parameter int IN_W  = 9,
  parameter int W_W   = 10,
  parameter int OUT_W = 8,
  parameter int FRAC  = 9,
  parameter int SAT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  nn_neuron_mac_seq_if.slave bus
);
  localparam int AW    = $clog2(N_IN + 1);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int P_W   = IN_W + W_W;
  // Wrap mode keeps the legacy OUT_W accumulator; saturating mode is wide enough never to overflow
  localparam int ACC_W = (SAT != 0) ? P_W + $clog2(N_IN + 2) : OUT_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic signed [W_W-1:0]   w_q [N_IN];
  logic signed [OUT_W-1:0] bias_q;
  logic signed [IN_W-1:0]  x_q [N_IN];
  logic signed [IN_W-1:0]  sub_q;
  logic [IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [OUT_W-1:0]        out_q;

  logic                    accept;
  logic                    last;
  logic                    coef_wr;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [OUT_W-1:0] result;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign last    = (state_q == BUSY) && (idx_q == IDX_W'(N_IN - 1));
  // Coefficients are frozen while a computation is in flight
  assign coef_wr = bus.w_we && (state_q != BUSY);
  assign prod    = P_W'(x_q[idx_q]) * P_W'(w_q[idx_q]);
  assign acc_sum = acc_q + term;
  assign bus.out_data = out_q;

  generate
    if (SAT != 0) begin : g_sat
      localparam int R_W = ACC_W + 2;
      localparam logic signed [R_W-1:0] HI = R_W'((2 ** (OUT_W - 1)) - 1);
      localparam logic signed [R_W-1:0] LO = R_W'(-(2 ** (OUT_W - 1)));
      logic signed [R_W-1:0] wide;

      assign term = ACC_W'(prod >>> FRAC);

      // Full-precision final sum, clamped into the output range
      always_comb begin
        wide = R_W'(acc_sum) + R_W'(bias_q) - R_W'(sub_q);
        if (wide > HI)      result = HI[OUT_W-1:0];
        else if (wide < LO) result = LO[OUT_W-1:0];
        else                result = wide[OUT_W-1:0];
      end
    end else begin : g_wrap
      // Bit-exact with the combinational layers: fixed product slice, modulo arithmetic
      assign term   = prod[FRAC+OUT_W-1:FRAC];
      assign result = acc_sum + bias_q - sub_q[OUT_W-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs: accept, N_IN busy cycles, hold until taken
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: if (last) state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, multiply-accumulate and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      sub_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_IN; i++) x_q[i] <= bus.in_vec[i*IN_W +: IN_W];
      sub_q <= bus.in_sub;
      idx_q <= '0;
      acc_q <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_sum;
      idx_q <= last ? '0 : idx_q + 1'b1;
      if (last) out_q <= result;
    end
  end

  // Coefficient register file: weights at 0..N_IN-1, bias at N_IN, higher addresses ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      bias_q <= '0;
    end else if (coef_wr) begin
      if (bus.w_addr == AW'(N_IN))     bias_q <= bus.w_data[OUT_W-1:0];
      else if (bus.w_addr < AW'(N_IN)) w_q[bus.w_addr[IDX_W-1:0]] <= bus.w_data;
    end
  end
endmodule

// File: tb/tb_nn_neuron_mac_seq.sv
// tb/tb_nn_neuron_mac_seq.sv - scoreboard bench for nn_neuron_mac_seq in wrap, saturating and single-input builds
module tb_nn_neuron_mac_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nn_neuron_mac_seq_if #(.N_IN(6)) bus0 ();
  nn_neuron_mac_seq_if #(.N_IN(6)) bus1 ();
  nn_neuron_mac_seq_if #(.N_IN(1)) bus2 ();

  nn_neuron_mac_seq #(.N_IN(6), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  nn_neuron_mac_seq #(.N_IN(6), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  nn_neuron_mac_seq #(.N_IN(1), .SAT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  int q2[$];
  int xs[6];
  logic signed [9:0] wsh[6];
  logic signed [7:0] bsh;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div512(input int p);
    int q;
    q = p / 512;
    if (p < 0 && (p % 512) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int wrap8(input int s);
    int r;
    r = s & 255;
    if (r > 127) r = r - 256;
    return r;
  endfunction

  function automatic int model(input bit sat, input int sub);
    int s;
    s = 0;
    for (int i = 0; i < 6; i++) s += floor_div512(xs[i] * int'(wsh[i]));
    s = s + int'(bsh) - sub;
    if (sat) begin
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
    end else begin
      s = wrap8(s);
    end
    return s;
  endfunction

  task automatic set_wr(input int addr, input int data, input logic we);
    bus0.w_we = we; bus0.w_addr = 3'(addr); bus0.w_data = 10'(data);
    bus1.w_we = we; bus1.w_addr = 3'(addr); bus1.w_data = 10'(data);
  endtask

  task automatic wr(input int addr, input int data);
    set_wr(addr, data, 1'b1);
    @(posedge clk); #1;
    set_wr(0, 0, 1'b0);
    if (addr < 6) wsh[addr] = 10'(data);
    else if (addr == 6) bsh = 8'(data);
  endtask

  task automatic load_t1();
    wr(0, 'h015); wr(1, 'h3B5); wr(2, 'h00B);
    wr(3, 'h00D); wr(4, 'h017); wr(5, 'h018);
    wr(6, 'h044);
  endtask

  // mode: 0 plain, 1 write w0 during BUSY, 2 reset mid-BUSY, 3 write w0 in the accept cycle
  task automatic send(input int sub, input int mode);
    int lat;
    logic [53:0] v;
    for (int i = 0; i < 6; i++) v[i*9 +: 9] = 9'(xs[i]);
    bus0.in_vec = v; bus1.in_vec = v;
    bus0.in_sub = 9'(sub); bus1.in_sub = 9'(sub);
    if (mode == 3) begin
      set_wr(0, 'h07F, 1'b1);
      wsh[0] = 10'h07F;
    end
    check("in_ready_pre0", bus0.in_ready, 1);
    check("in_ready_pre1", bus1.in_ready, 1);
    q0.push_back(model(1'b0, sub));
    q1.push_back(model(1'b1, sub));
    bus0.in_valid = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    set_wr(0, 0, 1'b0);
    v = 54'({$urandom(), $urandom()});
    bus0.in_vec = v; bus1.in_vec = v;
    bus0.in_sub = 9'($urandom()); bus1.in_sub = bus0.in_sub;
    lat = 1;
    while (bus0.out_valid !== 1'b1 && lat < 20) begin
      if (mode == 1 && lat == 3) set_wr(0, 'h07F, 1'b1);
      if (mode == 1 && lat == 4) set_wr(0, 0, 1'b0);
      if (mode == 2 && lat == 4) begin
        rst_n = 1'b0; #1;
        check("rst_valid0", bus0.out_valid, 0);
        check("rst_valid1", bus1.out_valid, 0);
        check("rst_data0", bus0.out_data, 0);
        check("rst_data1", bus1.out_data, 0);
        check("rst_ready0", bus0.in_ready, 1);
        void'(q0.pop_back());
        void'(q1.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) wsh[i] = '0;
        bsh = '0;
        repeat (8) @(posedge clk);
        #1;
        check("no_partial0", bus0.out_valid, 0);
        check("no_partial1", bus1.out_valid, 0);
        check("rel_ready0", bus0.in_ready, 1);
        check("rel_ready1", bus1.in_ready, 1);
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 7);
    check("valid_sat1", bus1.out_valid, 1);
  endtask

  task automatic recv(input int hold);
    logic [7:0] d0, d1;
    d0 = bus0.out_data; d1 = bus1.out_data;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check("hold_data0", bus0.out_data, d0);
      check("hold_data1", bus1.out_data, d1);
      check("hold_valid", bus0.out_valid, 1);
      check("hold_in_ready", bus0.in_ready, 0);
    end
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
    if (q0.size() == 0 || q1.size() == 0) check("sb_empty", 0, 1);
    else begin
      check("out_wrap", int'($signed(bus0.out_data)), q0.pop_front());
      check("out_sat", int'($signed(bus1.out_data)), q1.pop_front());
    end
    @(posedge clk); #1;
    bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
    check("valid_drop", bus0.out_valid, 0);
    check("ready_back", bus0.in_ready, 1);
    check("data_keep0", bus0.out_data, d0);
    check("data_keep1", bus1.out_data, d1);
  endtask

  task automatic run_one(input int x, input int w, input int b);
    int lat;
    bus2.w_we = 1'b1; bus2.w_addr = 1'b0; bus2.w_data = 10'(w);
    @(posedge clk); #1;
    bus2.w_addr = 1'b1; bus2.w_data = 10'(b);
    @(posedge clk); #1;
    bus2.w_we = 1'b0;
    bus2.in_vec = 9'(x); bus2.in_sub = '0;
    q2.push_back(wrap8(floor_div512(x * w) + b));
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    lat = 1;
    while (bus2.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_n1", lat, 2);
    bus2.out_ready = 1'b1;
    if (q2.size() == 0) check("sb_empty_n1", 0, 1);
    else check("out_n1", int'($signed(bus2.out_data)), q2.pop_front());
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
    check("valid_drop_n1", bus2.out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.in_vec = '0; bus0.in_sub = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_vec = '0; bus1.in_sub = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_vec = '0; bus2.in_sub = '0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    bus2.w_we = 1'b0; bus2.w_addr = '0; bus2.w_data = '0;
    set_wr(0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin wsh[i] = '0; xs[i] = 0; end
    bsh = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid0", bus0.out_valid, 0);
    check("reset_valid1", bus1.out_valid, 0);
    check("reset_valid2", bus2.out_valid, 0);
    check("reset_data0", bus0.out_data, 0);
    check("reset_data2", bus2.out_data, 0);
    check("reset_ready0", bus0.in_ready, 1);
    check("reset_ready2", bus2.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_t1();
    send(4, 0); recv(0);

    xs[0] = 255; send(0, 0); recv(0);
    xs[0] = 0; xs[1] = 100; send(0, 0); recv(0);

    for (int i = 0; i < 6; i++) begin wr(i, 'h1FF); xs[i] = 255; end
    send(0, 0); recv(0);
    for (int i = 0; i < 6; i++) wr(i, 'h200);
    send(0, 0); recv(0);

    xs[0] = 3; xs[1] = -7; xs[2] = 100; xs[3] = -256; xs[4] = 255; xs[5] = 1;
    send(17, 0); recv(5);

    load_t1();
    for (int i = 0; i < 6; i++) xs[i] = 0;
    xs[0] = 255;
    send(0, 1); recv(0);
    wr(7, 'h155);
    send(0, 0); recv(0);
    send(0, 3); recv(0);

    send(0, 2);
    for (int i = 0; i < 6; i++) xs[i] = 0;
    send(4, 0); recv(0);

    run_one(100, 256, 0);
    run_one(-200, 300, -3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
